// File: rtl/mb8_arb_pkg.sv
// mb8_arb_pkg -- shared types and constants for the byte-memory arbiter.
//   arb_own_t        : which requester currently owns the memory port
//   IU / U8          : byte-address and data widths of the mb8 memory bus
//   MB8_MAX_WAIT_DEF : default host refusal limit before it preempts the core
//   MB8_BURST_DEF    : default host burst length while the core is requesting
package mb8_arb_pkg;

  localparam int IU = 17;
  localparam int U8 = 8;

  localparam int MB8_MAX_WAIT_DEF = 8;
  localparam int MB8_BURST_DEF    = 4;

  typedef enum logic {OWN_CORE, OWN_HOST} arb_own_t;

endpackage

// File: rtl/mb8_arb_if.sv
// mb8_arb_if -- bundle of the core port, host port and memory bus around mb8_arb.
//   core : c_req, c_we, c_addr, c_wdata -> arbiter; c_rdata, c_hold <- arbiter
//   host : h_req, h_we, h_addr, h_wdata -> arbiter; h_ack, h_rdata <- arbiter
//   mem  : m_we, m_addr, m_wdata <- arbiter; m_rdata -> arbiter
// modport slave is the arbiter's view; modport master is the environment's view
// (requesters plus the memory model).
interface mb8_arb_if;
  import mb8_arb_pkg::*;

  logic          c_req;
  logic          c_we;
  logic [IU-1:0] c_addr;
  logic [U8-1:0] c_wdata;
  logic [U8-1:0] c_rdata;
  logic          c_hold;

  logic          h_req;
  logic          h_we;
  logic [IU-1:0] h_addr;
  logic [U8-1:0] h_wdata;
  logic          h_ack;
  logic [U8-1:0] h_rdata;

  logic          m_we;
  logic [IU-1:0] m_addr;
  logic [U8-1:0] m_wdata;
  logic [U8-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_rdata, c_hold,
    input  h_req, h_we, h_addr, h_wdata,
    output h_ack, h_rdata,
    output m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_rdata, c_hold,
    output h_req, h_we, h_addr, h_wdata,
    input  h_ack, h_rdata,
    input  m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/mb8_arb_stat.sv
// mb8_arb_stat -- statistics counters for mb8_arb (only built with MB8_ARB_STAT_EN).
//   clk, rst  : clock, synchronous active-low reset (clears both counters)
//   stall_i   : core is held this cycle
//   hgnt_i    : host is granted this cycle
//   stall_cnt : count of held cycles, wraps at 2^32
//   hgnt_cnt  : count of host grants, wraps at 2^32
module mb8_arb_stat (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        hgnt_i,
  output logic [31:0] stall_cnt,
  output logic [31:0] hgnt_cnt
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] hgnt_cnt_q,  hgnt_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    hgnt_cnt_d  = hgnt_cnt_q;
    if (stall_i) stall_cnt_d = stall_cnt_q + 32'd1;
    if (hgnt_i)  hgnt_cnt_d  = hgnt_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      hgnt_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      hgnt_cnt_q  <= hgnt_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign hgnt_cnt  = hgnt_cnt_q;

endmodule

// File: rtl/mb8_arb.sv
// mb8_arb -- shares the single 8-bit memory port between the eJ32 core and a
// host requester. The core has priority; a refused host preempts the core after
// MAX_WAIT cycles and then keeps the port for up to BURST grants while the core
// is requesting. With the core idle the host streams without limit.
//   clk, rst : clock, synchronous active-low reset
//   bus      : mb8_arb_if.slave (core port, host port, memory bus)
//   stall_cnt, hgnt_cnt : statistics outputs, present only with MB8_ARB_STAT_EN
// Optional feature macro: MB8_ARB_STAT_EN
module mb8_arb
  import mb8_arb_pkg::*;
#(
  parameter int MAX_WAIT = MB8_MAX_WAIT_DEF,
  parameter int BURST    = MB8_BURST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mb8_arb_if.slave    bus
`ifdef MB8_ARB_STAT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] hgnt_cnt
`endif
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [7:0] BURST_C    = 8'(BURST);

  arb_own_t   owner_q, owner_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;

  logic host_gnt;
  logic core_gnt;
  logic c_hold;

  // Grant decision; nothing is granted while reset is asserted so a burst
  // interrupted by reset never writes its pending byte.
  always_comb begin
    host_gnt = 1'b0;
    if (rst && bus.h_req) begin
      if (owner_q == OWN_HOST) host_gnt = !bus.c_req || (burst_cnt_q < BURST_C);
      else                     host_gnt = !bus.c_req || (wait_cnt_q == MAX_WAIT_C);
    end
    core_gnt = rst && bus.c_req && !host_gnt;
    c_hold   = rst && bus.c_req && !core_gnt;
  end

  assign bus.m_we    = host_gnt ? bus.h_we    : (core_gnt ? bus.c_we : 1'b0);
  assign bus.m_addr  = host_gnt ? bus.h_addr  : bus.c_addr;
  assign bus.m_wdata = host_gnt ? bus.h_wdata : bus.c_wdata;
  assign bus.c_hold  = c_hold;
  assign bus.h_ack   = host_gnt;
  assign bus.c_rdata = bus.m_rdata;
  assign bus.h_rdata = bus.m_rdata;

  // A non-granted cycle always hands ownership back to the core, so dropping
  // h_req mid-burst ends the burst at once and restarts the wait count.
  always_comb begin
    owner_d     = owner_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    if (host_gnt) begin
      owner_d     = OWN_HOST;
      wait_cnt_d  = '0;
      if (burst_cnt_q != BURST_C) burst_cnt_d = burst_cnt_q + 8'd1;
    end else begin
      owner_d     = OWN_CORE;
      burst_cnt_d = '0;
      if (!bus.h_req)                    wait_cnt_d = '0;
      else if (wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q     <= OWN_CORE;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      owner_q     <= owner_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef MB8_ARB_STAT_EN
  mb8_arb_stat u_stat (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (c_hold),
    .hgnt_i    (host_gnt),
    .stall_cnt (stall_cnt),
    .hgnt_cnt  (hgnt_cnt)
  );
`endif

endmodule

// File: doc/mb8_arb.md
# mb8_arb

Byte-memory arbiter that shares the single 8-bit `mb8_io` memory port (spram8_128k) between the eJ32 core and a host requester (loader / console DMA filling TIB and draining OBUF). The core has priority. The host is guaranteed service after a bounded wait and may hold the port for a bounded burst. The core is frozen through `c_hold` while the host owns the port. It sits between eJ32 and the memory bus in the top level, replacing the direct addr/data hookup.

## Interface
Parameters:
- MAX_WAIT, 8, cycles a requesting host may be refused before it preempts the core (1..255)
- BURST, 4, max consecutive host grants while the core is requesting (1..255)

Ports:
- clk  in  1  system clock; memory samples on ~clk
- rst  in  1  synchronous, active-low reset
- c_req  in  1  core accesses memory this cycle
- c_we  in  1  core write strobe
- c_addr  in  17 (`IU)  core byte address
- c_wdata  in  8  core write data
- c_rdata  out  8  read data to core; equals m_rdata
- c_hold  out  1  core must freeze all state this cycle
- h_req  in  1  host access request; hold addr/we/wdata stable until h_ack
- h_we  in  1  host write strobe
- h_addr  in  17  host byte address
- h_wdata  in  8  host write data
- h_ack  out  1  host access completes at this posedge
- h_rdata  out  8  host read data, valid when h_ack=1
- m_we  out  1  to memory bus: put_u8 when 1, else get_u8
- m_addr  out  17  to memory bus
- m_wdata  out  8  to memory bus
- m_rdata  in  8  memory bus vo, valid within the same clk cycle

## Operation
- Owner state `owner` ∈ {OWN_CORE, OWN_HOST}. Registers: `wait_cnt` (saturates at MAX_WAIT) and `burst_cnt` (0..BURST).
- Grant decision is combinational, one grant per cycle:
  - OWN_CORE: host_gnt = h_req && (!c_req || wait_cnt==MAX_WAIT). Otherwise core_gnt = c_req.
  - OWN_HOST: host_gnt = h_req && (!c_req || burst_cnt<BURST). Otherwise core_gnt = c_req.
- Mux: host_gnt selects h_*; otherwise c_*. m_we = granted side's we, and 0 when neither side is granted or rst=0.
- c_hold = c_req && !core_gnt. h_ack = host_gnt. h_rdata = c_rdata = m_rdata.
- Next-state rules:
  - host_gnt: owner←OWN_HOST, burst_cnt←burst_cnt+1 (saturating), wait_cnt←0.
  - otherwise: owner←OWN_CORE, burst_cnt←0. If h_req, wait_cnt←min(wait_cnt+1, MAX_WAIT); else wait_cnt←0.
- After a burst ends with the core requesting, the core gets at least MAX_WAIT cycles before the next preemption.
- The core never needs to be idle for the host to make progress. With the core idle, the host streams every cycle with no burst limit.
- No address checking and no write merging. Same-address core/host accesses are serialized in grant order.

## Timing
- Zero-latency grant: a read completes in the granting cycle (memory updates on negedge). A write commits at the negedge of the grant cycle.
- Host handshake is valid/ready style. A transfer occurs on each posedge with h_req=h_ack=1. The host may present the next byte in the following cycle.
- Reset (rst=0 at posedge): owner=OWN_CORE, wait_cnt=0, burst_cnt=0. While rst=0: m_we=0, h_ack=0, c_hold=0.
- Reset asserted mid-burst aborts the burst. The granted byte in that cycle is not written.
- h_req dropped mid-burst: ownership returns to the core the same cycle.

## Configuration
- MB8_ARB_STAT_EN defined: adds outputs `stall_cnt` (out 32, cycles with c_hold=1) and `hgnt_cnt` (out 32, host grants). Both are cleared by rst and wrap at 2^32.
- Not defined: those ports and their counters do not exist. Arbitration behaviour is identical in both builds.

## Structure
- ej32_pkg: `typedef enum logic {OWN_CORE, OWN_HOST} arb_own_t;` plus default MAX_WAIT and BURST constants.
- Widths use the existing `IU/`U8 macros from eJ32.vh.
- Sub-module mb8_arb_stat holds the two counters. It is instantiated only under MB8_ARB_STAT_EN.

## Test plan
- c_req=1 always, h_req=0: c_hold=0 every cycle, m_addr=c_addr; a write of 0x5A to 0x1000 then a read returns 0x5A.
- c_req=1, h_req=1 from cycle 0 (MAX_WAIT=8, BURST=4): h_ack=1 in cycles 8–11, c_hold=1 in cycles 8–11, core granted in cycles 12–19, next h_ack in cycle 20.
- c_req=0, host writes 16 bytes "0x41.." to TIB 0x1000..0x100F: h_ack=1 for 16 consecutive cycles; core readback matches.
- Host drops h_req after 2 grants of a burst: core granted the next cycle, and wait_cnt restarts at 0.
- rst=0 asserted at the third grant of a host burst: m_we=0 that cycle, the target byte is unchanged, and after release owner=OWN_CORE with counters 0.
- With MB8_ARB_STAT_EN, after the second scenario run for 24 cycles: stall_cnt=8, hgnt_cnt=8.
